// File: rtl/fb_write_arbiter.sv
// Write-port controller for the 80x60 RGB444 frame buffer: round-robin camera/overlay
// arbitration, (x,y) to linear address conversion, and frame-aligned freeze/resume.
module fb_write_arbiter #(
  parameter int unsigned C_COLS    = 80,
  parameter int unsigned C_ROWS    = 60,
  parameter int unsigned C_NB_ADDR = 13,
  parameter int unsigned C_NB_PIX  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cam_valid,
  output logic                 cam_ready,
  input  logic [6:0]           cam_x,
  input  logic [5:0]           cam_y,
  input  logic [C_NB_PIX-1:0]  cam_rgb,
  input  logic                 cam_frame_start,
  input  logic                 ovl_valid,
  output logic                 ovl_ready,
  input  logic [6:0]           ovl_x,
  input  logic [5:0]           ovl_y,
  input  logic [C_NB_PIX-1:0]  ovl_rgb,
  input  logic                 freeze_req,
  output logic                 frozen,
  output logic                 wr_en,
  output logic [C_NB_ADDR-1:0] wr_addr,
  output logic [C_NB_PIX-1:0]  wr_data,
  output logic [7:0]           drop_cnt
);

  localparam logic [6:0] COLS_X = 7'(C_COLS);
  localparam logic [5:0] ROWS_Y = 6'(C_ROWS);

  typedef enum logic [1:0] {LIVE, FREEZE_PEND, FROZEN, RESUME_PEND} state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 cam_en;
  logic                 last_cam;
  logic                 cam_req;
  logic                 grant_cam;
  logic                 grant_ovl;
  logic                 xfer;
  logic                 in_range;
  logic [6:0]           sel_x;
  logic [5:0]           sel_y;
  logic [C_NB_PIX-1:0]  sel_rgb;
  logic [C_NB_ADDR-1:0] y_ext;
  logic [C_NB_ADDR-1:0] addr;

  // Capture state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= LIVE;
    else      state <= state_nxt;
  end

  // Next state and camera enable; a frame_start beat belongs to the new frame
  always_comb begin
    state_nxt = state;
    cam_en    = 1'b0;
    unique case (state)
      LIVE: begin
        cam_en = 1'b1;
        if (freeze_req) state_nxt = FREEZE_PEND;
      end
      FREEZE_PEND: begin
        cam_en = !(cam_frame_start && freeze_req);
        if (!freeze_req)          state_nxt = LIVE;
        else if (cam_frame_start) state_nxt = FROZEN;
      end
      FROZEN: begin
        if (!freeze_req) state_nxt = RESUME_PEND;
      end
      RESUME_PEND: begin
        cam_en = cam_frame_start;
        if (freeze_req)           state_nxt = FROZEN;
        else if (cam_frame_start) state_nxt = LIVE;
      end
      default: state_nxt = LIVE;
    endcase
  end

  // Round-robin grant; a suppressed camera beat is swallowed without using a slot
  always_comb begin
    cam_req   = cam_valid && cam_en;
    grant_cam = cam_req && (!ovl_valid || !last_cam);
    grant_ovl = ovl_valid && (!cam_req || last_cam);
    xfer      = grant_cam || grant_ovl;
    sel_x     = grant_cam ? cam_x   : ovl_x;
    sel_y     = grant_cam ? cam_y   : ovl_y;
    sel_rgb   = grant_cam ? cam_rgb : ovl_rgb;
    in_range  = (sel_x < COLS_X) && (sel_y < ROWS_Y);
    y_ext     = C_NB_ADDR'(sel_y);
    addr      = (y_ext << 6) + (y_ext << 4) + C_NB_ADDR'(sel_x);
  end

  assign cam_ready = rst && (!cam_en || grant_cam);
  assign ovl_ready = rst && grant_ovl;

  // Write port, drop counter, arbitration history and frozen flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      drop_cnt <= 8'd0;
      last_cam <= 1'b0;
      frozen   <= 1'b0;
    end else begin
      wr_en  <= xfer && in_range;
      frozen <= (state_nxt == FROZEN) || (state_nxt == RESUME_PEND);
      if (xfer) last_cam <= grant_cam;
      if (xfer && in_range) begin
        wr_addr <= addr;
        wr_data <= sel_rgb;
      end
      if (xfer && !in_range && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Scenario and randomized checks of fb_write_arbiter against a behavioural model.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cam_valid = 1'b0, cam_frame_start = 1'b0;
  logic        ovl_valid = 1'b0, freeze_req = 1'b0;
  logic [6:0]  cam_x = '0, ovl_x = '0;
  logic [5:0]  cam_y = '0, ovl_y = '0;
  logic [11:0] cam_rgb = '0, ovl_rgb = '0;
  logic        cam_ready, ovl_ready, frozen, wr_en;
  logic [12:0] wr_addr;
  logic [11:0] wr_data;
  logic [7:0]  drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: frozen flag plus last-seen freeze_req; pending transitions are derived from both
  bit        m_frozen, m_prev_req, m_last_cam, m_wr_en;
  int        m_addr, m_data, m_drop;
  bit        e_cam_ready, e_ovl_ready, a_cam_ready, a_ovl_ready;

  fb_write_arbiter dut (
    .clk(clk), .rst(rst),
    .cam_valid(cam_valid), .cam_ready(cam_ready), .cam_x(cam_x), .cam_y(cam_y),
    .cam_rgb(cam_rgb), .cam_frame_start(cam_frame_start),
    .ovl_valid(ovl_valid), .ovl_ready(ovl_ready), .ovl_x(ovl_x), .ovl_y(ovl_y),
    .ovl_rgb(ovl_rgb), .freeze_req(freeze_req), .frozen(frozen),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .drop_cnt(drop_cnt)
  );

  always #20 clk = ~clk;

  task automatic model_reset();
    m_frozen = 0; m_prev_req = 0; m_last_cam = 0; m_wr_en = 0;
    m_addr = 0; m_data = 0; m_drop = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cam_valid = 0; ovl_valid = 0; cam_frame_start = 0; freeze_req = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Drive one cycle of inputs, capture the readies, then advance the model past the edge
  task automatic step(input bit cv, input int cx, input int cy, input int crgb, input bit cfs,
                      input bit ov, input int ox, input int oy, input int orgb, input bit frz);
    bit cen, creq, gcam, govl, pend_frz, pend_res;
    int sx, sy, srgb;
    @(negedge clk);
    cam_valid = cv; cam_x = 7'(cx); cam_y = 6'(cy); cam_rgb = 12'(crgb); cam_frame_start = cfs;
    ovl_valid = ov; ovl_x = 7'(ox); ovl_y = 6'(oy); ovl_rgb = 12'(orgb); freeze_req = frz;
    #1;
    pend_frz = !m_frozen && m_prev_req;
    pend_res = m_frozen && !m_prev_req;
    cen  = (!m_frozen && !(pend_frz && frz && cfs)) || (pend_res && cfs);
    creq = cv && cen;
    gcam = creq && (!ov || !m_last_cam);
    govl = ov && (!creq || m_last_cam);
    e_cam_ready = !cen || gcam;
    e_ovl_ready = govl;
    a_cam_ready = cam_ready;
    a_ovl_ready = ovl_ready;
    @(posedge clk);
    m_wr_en = 0;
    if (gcam || govl) begin
      sx = gcam ? cx : ox; sy = gcam ? cy : oy; srgb = gcam ? crgb : orgb;
      if (sx < 80 && sy < 60) begin
        m_wr_en = 1; m_addr = sy * 80 + sx; m_data = srgb;
      end else if (m_drop < 255) m_drop = m_drop + 1;
      m_last_cam = gcam;
    end
    if (pend_frz && frz && cfs) m_frozen = 1;
    else if (pend_res && !frz && cfs) m_frozen = 0;
    m_prev_req = frz;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; cam_valid = 1; ovl_valid = 1;
    #3;
    n_tests++; if (cam_ready !== 1'b0 || ovl_ready !== 1'b0) begin n_fail++;
      $display("FAIL reset_ready: cam=%b ovl=%b want 0 0", cam_ready, ovl_ready); end
    do_reset();
    #1;
    n_tests++; if ({wr_en, frozen} !== 2'b00 || wr_addr !== 13'd0 || wr_data !== 12'd0 || drop_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_vals: wr_en=%b frozen=%b addr=%0d data=%h drop=%0d want all 0",
                         wr_en, frozen, wr_addr, wr_data, drop_cnt); end
  endtask

  task automatic test_single();
    step(1, 3, 2, 'hABC, 0, 0, 0, 0, 0, 0);
    n_tests++; if (a_cam_ready !== 1'b1) begin n_fail++;
      $display("FAIL single_ready: got %b want 1", a_cam_ready); end
    n_tests++; if (wr_en !== 1'b1 || wr_addr !== 13'd163 || wr_data !== 12'hABC) begin n_fail++;
      $display("FAIL single_write: en=%b addr=%0d data=%h want 1 163 abc", wr_en, wr_addr, wr_data); end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n_tests++; if (wr_en !== 1'b0 || wr_addr !== 13'd163 || wr_data !== 12'hABC) begin n_fail++;
      $display("FAIL single_hold: en=%b addr=%0d data=%h want 0 163 abc", wr_en, wr_addr, wr_data); end
  endtask

  task automatic test_back_to_back();
    int want_data[4] = '{'h100, 'h201, 'h102, 'h203};
    bit want_cam[4]  = '{1, 0, 1, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, i, 0, 'h100 + i, 0, 1, i, 1, 'h200 + i, 0);
      n_tests++; if (a_cam_ready !== want_cam[i] || a_ovl_ready !== !want_cam[i]) begin n_fail++;
        $display("FAIL rr_grant%0d: cam=%b ovl=%b want cam=%b", i, a_cam_ready, a_ovl_ready, want_cam[i]); end
      n_tests++; if (wr_en !== 1'b1 || wr_data !== 12'(want_data[i])) begin n_fail++;
        $display("FAIL rr_write%0d: en=%b data=%h want 1 %h", i, wr_en, wr_data, want_data[i]); end
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    step(1, 80, 0, 'h111, 0, 0, 0, 0, 0, 0);
    n_tests++; if (a_cam_ready !== 1'b1 || wr_en !== 1'b0) begin n_fail++;
      $display("FAIL oor_x: ready=%b wr_en=%b want 1 0", a_cam_ready, wr_en); end
    step(0, 0, 0, 0, 0, 1, 0, 60, 'h222, 0);
    n_tests++; if (a_ovl_ready !== 1'b1 || wr_en !== 1'b0 || drop_cnt !== 8'd2) begin n_fail++;
      $display("FAIL oor_y: ready=%b wr_en=%b drop=%0d want 1 0 2", a_ovl_ready, wr_en, drop_cnt); end
    for (int i = 0; i < 300; i++) step(1, 80 + (i % 40), i % 64, i, 0, 0, 0, 0, 0, 0);
    n_tests++; if (drop_cnt !== 8'd255 || wr_en !== 1'b0) begin n_fail++;
      $display("FAIL oor_sat: drop=%0d wr_en=%b want 255 0", drop_cnt, wr_en); end
  endtask

  task automatic test_freeze();
    do_reset();
    step(1, 1, 1, 'h011, 0, 0, 0, 0, 0, 1);
    step(1, 2, 1, 'h012, 0, 0, 0, 0, 0, 1);
    n_tests++; if (wr_en !== 1'b1 || wr_addr !== 13'd82 || frozen !== 1'b0) begin n_fail++;
      $display("FAIL frz_pend_write: en=%b addr=%0d frozen=%b want 1 82 0", wr_en, wr_addr, frozen); end
    step(1, 0, 0, 'h0F0, 1, 0, 0, 0, 0, 1);
    n_tests++; if (a_cam_ready !== 1'b1 || wr_en !== 1'b0 || frozen !== 1'b1) begin n_fail++;
      $display("FAIL frz_enter: ready=%b en=%b frozen=%b want 1 0 1", a_cam_ready, wr_en, frozen); end
    step(1, 4, 4, 'h444, 0, 1, 79, 59, 'h5A5, 1);
    n_tests++; if (a_cam_ready !== 1'b1 || wr_en !== 1'b1 || wr_addr !== 13'd4799 || wr_data !== 12'h5A5) begin
      n_fail++; $display("FAIL frz_ovl: ready=%b en=%b addr=%0d data=%h want 1 1 4799 5a5",
                         a_cam_ready, wr_en, wr_addr, wr_data); end
    step(1, 6, 6, 'h666, 0, 0, 0, 0, 0, 0);
    step(1, 7, 7, 'h777, 0, 0, 0, 0, 0, 0);
    n_tests++; if (wr_en !== 1'b0 || frozen !== 1'b1) begin n_fail++;
      $display("FAIL res_pend: en=%b frozen=%b want 0 1", wr_en, frozen); end
    step(1, 5, 5, 'h555, 1, 0, 0, 0, 0, 0);
    n_tests++; if (wr_en !== 1'b1 || wr_addr !== 13'd405 || wr_data !== 12'h555 || frozen !== 1'b0) begin
      n_fail++; $display("FAIL resume: en=%b addr=%0d data=%h frozen=%b want 1 405 555 0",
                         wr_en, wr_addr, wr_data, frozen); end
  endtask

  task automatic test_abort();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(1, 10 + i, 3, 'h300 + i, 0, 0, 0, 0, 0, (i < 3));
      n_tests++; if (wr_en !== 1'b1 || wr_addr !== 13'(250 + i) || frozen !== 1'b0) begin n_fail++;
        $display("FAIL abort%0d: en=%b addr=%0d frozen=%b want 1 %0d 0", i, wr_en, wr_addr, frozen, 250 + i); end
    end
    step(1, 20, 3, 'h3FF, 1, 0, 0, 0, 0, 0);
    n_tests++; if (wr_en !== 1'b1 || frozen !== 1'b0) begin n_fail++;
      $display("FAIL abort_live_fs: en=%b frozen=%b want 1 0", wr_en, frozen); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1, 90, 0, 'h0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 'h0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 9, 9, 'h999, 1);
    n_tests++; if (wr_en !== 1'b1 || frozen !== 1'b1 || drop_cnt !== 8'd1) begin n_fail++;
      $display("FAIL mid_pre: en=%b frozen=%b drop=%0d want 1 1 1", wr_en, frozen, drop_cnt); end
    #5 rst = 1'b0;
    #1;
    n_tests++; if (wr_en !== 1'b0 || frozen !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++;
      $display("FAIL mid_async: en=%b frozen=%b drop=%0d want 0 0 0", wr_en, frozen, drop_cnt); end
    freeze_req = 0; cam_valid = 0; ovl_valid = 0; cam_frame_start = 0;
    model_reset();
    @(negedge clk); rst = 1'b1;
    step(1, 1, 0, 'hC01, 0, 1, 2, 0, 'hD02, 0);
    n_tests++; if (a_cam_ready !== 1'b1 || a_ovl_ready !== 1'b0 || wr_en !== 1'b1 || wr_data !== 12'hC01) begin
      n_fail++; $display("FAIL mid_first_grant: cam=%b ovl=%b en=%b data=%h want 1 0 1 c01",
                         a_cam_ready, a_ovl_ready, wr_en, wr_data); end
  endtask

  task automatic test_random();
    bit frz = 0;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) frz = !frz;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 85), $urandom_range(0, 63), $urandom_range(0, 4095),
           $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 85),
           $urandom_range(0, 63), $urandom_range(0, 4095), frz);
      n_tests++;
      if (a_cam_ready !== e_cam_ready || a_ovl_ready !== e_ovl_ready || wr_en !== m_wr_en ||
          wr_addr !== 13'(m_addr) || wr_data !== 12'(m_data) || drop_cnt !== 8'(m_drop) ||
          frozen !== m_frozen) begin
        n_fail++;
        if (bad < 10) $display("FAIL rand%0d: crdy=%b/%b ordy=%b/%b en=%b/%b addr=%0d/%0d data=%h/%h drop=%0d/%0d frz=%b/%b (got/want)",
          i, a_cam_ready, e_cam_ready, a_ovl_ready, e_ovl_ready, wr_en, m_wr_en, wr_addr, m_addr,
          wr_data, m_data, drop_cnt, m_drop, frozen, m_frozen);
        bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_out_of_range();
    test_freeze();
    test_abort();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Write-side controller for the 80x60, 12-bit RGB444 BRAM frame buffer that the OLED scan-out path reads. It shares the single buffer write port between the camera capture stream and an overlay/drawing stream using round-robin arbitration. It converts (x, y) pixel coordinates into linear buffer addresses and discards out-of-range beats. It also runs the freeze/resume sequencing behind the "stop capture" button, switching only at camera frame boundaries so the displayed image is never a mix of two frames.

## Interface
Parameters:
- C_COLS, 80, image columns
- C_ROWS, 60, image rows
- C_NB_ADDR, 13, buffer address width (80*60 = 4800 ≤ 2^13)
- C_NB_PIX, 12, buffer word width (4/4/4 RGB)

Ports:
- clk  in  1  system clock (25 MHz)
- rst  in  1  reset, asynchronous, active-low
- cam_valid  in  1  camera beat valid
- cam_ready  out  1  camera beat accepted (combinational)
- cam_x  in  7  camera column
- cam_y  in  6  camera row
- cam_rgb  in  12  camera pixel
- cam_frame_start  in  1  one-cycle pulse, first beat of a camera frame
- ovl_valid  in  1  overlay beat valid
- ovl_ready  out  1  overlay beat accepted (combinational)
- ovl_x  in  7  overlay column
- ovl_y  in  6  overlay row
- ovl_rgb  in  12  overlay pixel
- freeze_req  in  1  level; 1 = stop capture (already debounced)
- frozen  out  1  camera writes currently suppressed
- wr_en  out  1  buffer write strobe
- wr_addr  out  C_NB_ADDR  buffer address
- wr_data  out  C_NB_PIX  buffer data
- drop_cnt  out  8  saturating count of out-of-range accepted beats

## Operation
- A beat transfers when valid & ready are both high. Valid must not depend on ready.
- Capture FSM states: LIVE, FREEZE_PEND, FROZEN, RESUME_PEND. Reset state is LIVE.
  - LIVE: if freeze_req, go to FREEZE_PEND.
  - FREEZE_PEND: if !freeze_req, go to LIVE. Else if cam_frame_start, go to FROZEN. Frame_start takes precedence only while freeze_req=1.
  - FROZEN: if !freeze_req, go to RESUME_PEND.
  - RESUME_PEND: if freeze_req, go to FROZEN. Else if cam_frame_start, go to LIVE.
- cam_frame_start is evaluated against the current state. A camera beat in the same cycle belongs to the new frame:
  - In FREEZE_PEND, that beat is discarded.
  - In RESUME_PEND, that beat is written.
- Camera enable (cam_en) = state ∈ {LIVE, FREEZE_PEND}, excluding the FREEZE_PEND & cam_frame_start & freeze_req cycle. Also cam_en = 1 in RESUME_PEND when cam_frame_start=1.
- When cam_en=0:
  - cam_ready = 1.
  - The beat is consumed silently: no write, no drop count, no arbitration slot used.
- Arbitration applies when both enabled requesters are valid. The grant goes to the requester not granted last (last_grant register).
  - last_grant resets to OVL, so the camera wins the first contention.
  - last_grant updates only on a granted transfer.
  - A sole valid requester is granted immediately.
- Overlay writes are never suppressed by the FSM.
- Address = y*80 + x, formed as (y<<6)+(y<<4)+x and truncated to C_NB_ADDR. The maximum legal value is 4799.
- Out of range means x ≥ C_COLS or y ≥ C_ROWS. Such a beat is accepted with no write, and drop_cnt increments, saturating at 255.
- frozen = 1 in FROZEN and RESUME_PEND.

## Timing
- Latency: a transfer in cycle N produces wr_en/wr_addr/wr_data registered in cycle N+1.
- Throughput: 1 write per cycle, sustained.
- wr_en is high for exactly one cycle per written beat. wr_addr/wr_data hold their last values when wr_en=0.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, drop_cnt=0, frozen=0, FSM=LIVE, last_grant=OVL.
  - cam_ready/ovl_ready are combinational: during reset they are 0.
- Reset asserted mid-operation clears all registers immediately. A write registered in that cycle is lost, and no wr_en pulse is generated after reset.
- frozen and the FSM state update on the clock edge following the qualifying input.
- The drop_cnt increment is registered with the same 1-cycle latency as a write.

## Test plan
- Single camera beat: x=3, y=2, rgb=0xABC → one cycle later wr_en=1, wr_addr=163, wr_data=0xABC; cam_ready high in the accept cycle.
- Both valid for 4 cycles after reset → grants alternate CAM, OVL, CAM, OVL; 4 consecutive wr_en pulses.
- Out of range: x=80, y=0, then x=0, y=60 → both accepted, no wr_en, drop_cnt=2. Then 300 such beats → drop_cnt=255.
- Freeze sequence:
  - freeze_req=1 mid-frame → camera writes continue.
  - cam_frame_start with a beat → no write, frozen=1 next cycle.
  - Overlay beat at x=79, y=59 → wr_addr=4799 still written.
  - freeze_req=0 → frozen stays 1 until the next cam_frame_start, whose beat is written and frozen goes to 0.
- FREEZE_PEND abort: freeze_req pulsed 3 cycles with no frame_start → state returns to LIVE, frozen never asserts, all camera beats written.
- Reset mid-stream: rst low in the cycle after an accepted beat → wr_en=0 asynchronously, drop_cnt=0, FSM=LIVE; the first contention after release is won by CAM.
